// File: rtl/tt_memop_queue_fsm.sv
// tt_memop_queue_fsm: in-order queue of outstanding vector load/store memops.
// New memop uops can be accepted while the oldest memop holds the single
// OVI memop-sync channel. Commits retire the head in program order.
module tt_memop_queue_fsm #(
  parameter int unsigned NUM_SLOTS = 2,
  parameter int unsigned UOP_CNT_W = 4
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic                             i_load,
  input  logic                             i_store,
  input  logic                             i_id_ex_rts,
  input  logic                             i_ex_rtr,
  input  logic                             i_last_uop,
  input  logic                             i_lq_empty,
  input  logic                             i_mem_req,
  input  logic                             i_memop_sync_end,
  input  logic                             i_flush,
  output logic                             o_memop_sync_start,
  output logic                             o_completed_valid,
  output logic                             o_completed_store,
  output logic [UOP_CNT_W-1:0]             o_completed_uops,
  output logic                             o_wait_for_sync_end,
  output logic                             o_ovi_stall,
  output logic [$clog2(NUM_SLOTS+1)-1:0]   o_occupancy
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned OCC_W = $clog2(NUM_SLOTS + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {
    S_FREE    = 3'd0,
    S_PREPARE = 3'd1,
    S_READY   = 3'd2,
    S_BUSY    = 3'd3,
    S_COMMIT  = 3'd4
  } slot_state_e;

  slot_state_e                state_q    [NUM_SLOTS];
  slot_state_e                state_d    [NUM_SLOTS];
  logic [UOP_CNT_W-1:0]       uop_cnt_q  [NUM_SLOTS];
  logic [UOP_CNT_W-1:0]       uop_cnt_d  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]       is_store_q;
  logic [NUM_SLOTS-1:0]       is_store_d;
  logic [PTR_W-1:0]           head_q, head_d;
  logic [PTR_W-1:0]           tail_q, tail_d;
  logic                       sent_sync_q, sent_sync_d;

  logic [OCC_W-1:0]           occ;
  logic                       has_prep;
  logic [PTR_W-1:0]           prep_idx;
  slot_state_e                head_state;
  logic                       head_store;
  logic [UOP_CNT_W-1:0]       head_uops;
  logic                       queue_full;
  logic                       stall;
  logic                       uop_fire;
  logic                       sync_start;
  logic                       commit;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Occupancy and location of the (at most one) PREPARE entry
  always_comb begin
    occ      = '0;
    has_prep = 1'b0;
    prep_idx = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (state_q[i] != S_FREE) occ = occ + OCC_W'(1);
      if (state_q[i] == S_PREPARE) begin
        has_prep = 1'b1;
        prep_idx = PTR_W'(i);
      end
    end
  end

  // Head view, handshake qualifiers and combinational outputs
  always_comb begin
    head_state  = state_q[head_q];
    head_store  = is_store_q[head_q];
    head_uops   = uop_cnt_q[head_q];
    queue_full  = (occ == OCC_W'(NUM_SLOTS));
    stall       = queue_full & ~has_prep;
    uop_fire    = (i_load | i_store) & i_id_ex_rts & i_ex_rtr & ~stall;
    sync_start  = (head_state == S_BUSY) & (head_store | ~i_mem_req) & ~sent_sync_q;
    commit      = (head_state == S_COMMIT) & i_lq_empty;

    o_memop_sync_start  = sync_start;
    o_completed_valid   = commit;
    o_completed_store   = commit & head_store;
    o_completed_uops    = commit ? head_uops : '0;
    o_wait_for_sync_end = (head_state == S_BUSY) & sent_sync_q;
    o_ovi_stall         = stall;
    o_occupancy         = occ;
  end

  // Next-state: head progression, then flush (wins over allocation), then uop accept
  always_comb begin
    state_d     = state_q;
    uop_cnt_d   = uop_cnt_q;
    is_store_d  = is_store_q;
    head_d      = head_q;
    tail_d      = tail_q;
    sent_sync_d = sent_sync_q | sync_start;

    case (head_state)
      S_READY:  state_d[head_q] = S_BUSY;
      S_BUSY:   if (i_memop_sync_end) state_d[head_q] = S_COMMIT;
      S_COMMIT: if (commit) begin
        state_d[head_q] = S_FREE;
        head_d          = next_ptr(head_q);
      end
      default: ;
    endcase

    if (i_flush) begin
      // A READY head promoted above is not yet in sync, so it is discarded too
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        if (state_q[i] == S_PREPARE || state_q[i] == S_READY) state_d[i] = S_FREE;
      end
      tail_d = (head_state == S_BUSY || head_state == S_COMMIT) ? next_ptr(head_q) : head_q;
    end else if (uop_fire) begin
      if (has_prep) begin
        if (uop_cnt_q[prep_idx] != '1) uop_cnt_d[prep_idx] = uop_cnt_q[prep_idx] + UOP_CNT_W'(1);
        if (i_last_uop) state_d[prep_idx] = (prep_idx == head_q) ? S_BUSY : S_READY;
      end else begin
        is_store_d[tail_q] = i_store;
        uop_cnt_d[tail_q]  = UOP_CNT_W'(1);
        if (!i_last_uop)    state_d[tail_q] = S_PREPARE;
        else if (occ == '0) state_d[tail_q] = S_BUSY;
        else                state_d[tail_q] = S_READY;
        tail_d = next_ptr(tail_q);
      end
    end

    if (head_d != head_q || state_d[head_q] != S_BUSY) sent_sync_d = 1'b0;
  end

  // Registered queue state
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]   <= S_FREE;
        uop_cnt_q[i] <= '0;
      end
      is_store_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      sent_sync_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        state_q[i]   <= state_d[i];
        uop_cnt_q[i] <= uop_cnt_d[i];
      end
      is_store_q  <= is_store_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      sent_sync_q <= sent_sync_d;
    end
  end

endmodule

// File: doc/tt_memop_queue_fsm.md
Name: tt_memop_queue_fsm

Overview:
- Parametrised successor to the single-memop OVI sync FSM.
- Tracks up to NUM_SLOTS vector load/store memops in program order, so the next memop's uops can be received while the oldest one holds the single memop-sync channel.
- Counts uops per memop, commits strictly in order once the load queue drains, and supports a flush of memops that have not yet started sync.
- Sits between the VPU ID/EX dispatch handshake and the OVI memop-sync/completion interface.

Parameters:
- NUM_SLOTS, 2, outstanding memop entries (>=1; 1 reproduces the old single-memop behaviour).
- UOP_CNT_W, 4, width of the per-memop uop counter.

Ports:
- i_clk  input  1  clock
- i_reset_n  input  1  asynchronous active-low reset
- i_load  input  1  dispatched uop is a vector load
- i_store  input  1  dispatched uop is a vector store
- i_id_ex_rts  input  1  ID stage has a uop ready to send
- i_ex_rtr  input  1  EX stage ready to receive
- i_last_uop  input  1  dispatched uop is the memop's last
- i_lq_empty  input  1  load queue empty
- i_mem_req  input  1  load memory request outstanding from core
- i_memop_sync_end  input  1  OVI sync-end pulse for the head memop
- i_flush  input  1  discard every memop not yet in BUSY/COMMIT
- o_memop_sync_start  output  1  OVI sync-start pulse
- o_completed_valid  output  1  head memop completes this cycle
- o_completed_store  output  1  completing memop is a store
- o_completed_uops  output  UOP_CNT_W  uop count of the completing memop
- o_wait_for_sync_end  output  1  head is BUSY and sync_start has been issued
- o_ovi_stall  output  1  no slot can accept a new memop's first uop
- o_occupancy  output  $clog2(NUM_SLOTS+1)  number of non-FREE entries

Behaviour:
- Circular queue with head/tail pointers; pointers wrap at NUM_SLOTS.
- Per-entry state: FREE, PREPARE, READY, BUSY, COMMIT. Per-entry fields: is_store and uop_cnt.
- Only the head entry may be in BUSY or COMMIT.
- Uop fire: (i_load|i_store) & i_id_ex_rts & i_ex_rtr & !o_ovi_stall.
- o_ovi_stall = queue full & no PREPARE entry. Fires while stalled are illegal; the design does not need to handle them.
- First uop of a memop (no PREPARE entry exists):
  - Allocate the tail entry, latch is_store = i_store, set uop_cnt = 1, advance tail.
  - State = PREPARE if !i_last_uop.
  - State = BUSY if i_last_uop and the queue was empty. This matches the old single-cycle IDLE->BUSY path.
  - Otherwise state = READY.
- Subsequent uops: increment the PREPARE entry's uop_cnt, saturating at 2^UOP_CNT_W-1.
  - On i_last_uop: PREPARE->BUSY if the entry is head, else PREPARE->READY.
- Head promotion: head READY -> BUSY on the next edge.
- Sync-start:
  - o_memop_sync_start = head BUSY & (is_store | !i_mem_req) & !sent_sync.
  - sent_sync sets on the cycle sync_start is high.
  - sent_sync clears on any head change or when head leaves BUSY.
- o_wait_for_sync_end = head BUSY & sent_sync.
- Sync-end handling:
  - i_memop_sync_end while head BUSY: head -> COMMIT.
  - i_memop_sync_end otherwise: ignored.
- Commit:
  - Head COMMIT & i_lq_empty: o_completed_valid=1 combinationally, with o_completed_store/o_completed_uops from the head entry.
  - The entry frees and head advances on the same edge.
  - A READY successor reaches BUSY one cycle later.
  - o_completed_store and o_completed_uops are 0 when !o_completed_valid.
- Flush (i_flush):
  - Every FREE/PREPARE/READY entry becomes FREE.
  - Tail = head+1 if head is BUSY/COMMIT, else tail = head.
  - A uop fire in the same cycle is dropped.
  - Flush has priority over allocation. It does not affect the BUSY/COMMIT head.
- Simultaneous commit and allocate: both take effect. The allocating entry counts the queue as non-empty (goes READY, not BUSY), unless NUM_SLOTS=1 is full, in which case o_ovi_stall blocks the allocate.
- o_occupancy reflects registered state.
- Reset (async, any time including mid-sync):
  - All entries FREE, head=tail=0, sent_sync=0.
  - All outputs 0, except o_ovi_stall = 0 and o_occupancy = 0.

Test Plan:
- Single-uop store into empty queue -> BUSY on the next cycle; sync_start high 1 cycle with i_mem_req=1; sync_end -> COMMIT; with i_lq_empty=1, completed_valid for 1 cycle, completed_store=1, uops=1.
- 3-uop load (i_mem_req=1 for 4 cycles after BUSY) -> sync_start delayed until i_mem_req=0, then pulses exactly once; wait_for_sync_end=1 until sync_end; completion held off while i_lq_empty=0; completed_uops=3.
- NUM_SLOTS=2: memop A BUSY, memop B 2 uops -> B READY, occupancy=2, stall=1 for a third memop's first uop; A commits -> B BUSY 1 cycle later, stall=0.
- Flush with head BUSY and second entry PREPARE -> occupancy 2->1; head's sync_end still completes it normally.
- 20 uops with UOP_CNT_W=4 -> completed_uops saturates at 15.
- Reset asserted while head is BUSY and sent_sync=1 -> all outputs 0 asynchronously; after release, a new single-uop store behaves as in scenario 1.
